hack_keyboard_ctrl: RTL

Translates MiSTer-format PS/2 key events into Hack-platform key codes with shift-aware case, E0-extended key decoding, a multi-key held stack and a buffered event queue. Sits between the HPS `ps2_key` bus and the Hack memory-mapped keyboard register (`hack_scancode`, 0 when no key is held); the event queue serves consumers that must not miss keystrokes between polls.

---
 rtl/hack_kbd_pkg.sv | 28 ++
 rtl/hack_keymap.sv | 83 ++++++++
 rtl/hack_keyboard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared constants and types for the Hack keyboard controller: special key
// codes, shift scan ids and the held-stack entry layout.
package hack_kbd_pkg;

   localparam logic [7:0] KEY_NEWLINE   = 8'd128;
   localparam logic [7:0] KEY_BACKSPACE = 8'd129;
   localparam logic [7:0] KEY_LEFT      = 8'd130;
   localparam logic [7:0] KEY_UP        = 8'd131;
   localparam logic [7:0] KEY_RIGHT     = 8'd132;
   localparam logic [7:0] KEY_DOWN      = 8'd133;
   localparam logic [7:0] KEY_HOME      = 8'd134;
   localparam logic [7:0] KEY_END       = 8'd135;
   localparam logic [7:0] KEY_PGUP      = 8'd136;
   localparam logic [7:0] KEY_PGDN      = 8'd137;
   localparam logic [7:0] KEY_INSERT    = 8'd138;
   localparam logic [7:0] KEY_DELETE    = 8'd139;
   localparam logic [7:0] KEY_ESC       = 8'd140;
   localparam logic [7:0] KEY_F1        = 8'd141;

   localparam logic [8:0] SHIFT_L_ID = 9'h012;
   localparam logic [8:0] SHIFT_R_ID = 9'h059;

   typedef struct packed {
      logic [8:0] id;
      logic [7:0] code;
   } held_ent_t;

endpackage

// File: rtl/hack_keymap.sv
// Combinational PS/2 set-2 key id (E0 flag + scan code) to Hack code
// translation; returns 0 for keys with no Hack meaning.
module hack_keymap
   import hack_kbd_pkg::*;
#(
   parameter bit CASE_ENABLE = 1'b1
) (
   input  logic [8:0] id,
   input  logic       shift,
   output logic [7:0] code
);

   logic [7:0] base;
   logic [7:0] shifted;
   logic       letter;

   always_comb begin
      base    = '0;
      shifted = '0;
      unique case (id)
         9'h01C: base = 8'h41;  9'h032: base = 8'h42;  9'h021: base = 8'h43;
         9'h023: base = 8'h44;  9'h024: base = 8'h45;  9'h02B: base = 8'h46;
         9'h034: base = 8'h47;  9'h033: base = 8'h48;  9'h043: base = 8'h49;
         9'h03B: base = 8'h4A;  9'h042: base = 8'h4B;  9'h04B: base = 8'h4C;
         9'h03A: base = 8'h4D;  9'h031: base = 8'h4E;  9'h044: base = 8'h4F;
         9'h04D: base = 8'h50;  9'h015: base = 8'h51;  9'h02D: base = 8'h52;
         9'h01B: base = 8'h53;  9'h02C: base = 8'h54;  9'h03C: base = 8'h55;
         9'h02A: base = 8'h56;  9'h01D: base = 8'h57;  9'h022: base = 8'h58;
         9'h035: base = 8'h59;  9'h01A: base = 8'h5A;
         9'h016: {base, shifted} = {8'h31, 8'h21};
         9'h01E: {base, shifted} = {8'h32, 8'h40};
         9'h026: {base, shifted} = {8'h33, 8'h23};
         9'h025: {base, shifted} = {8'h34, 8'h24};
         9'h02E: {base, shifted} = {8'h35, 8'h25};
         9'h036: {base, shifted} = {8'h36, 8'h5E};
         9'h03D: {base, shifted} = {8'h37, 8'h26};
         9'h03E: {base, shifted} = {8'h38, 8'h2A};
         9'h046: {base, shifted} = {8'h39, 8'h28};
         9'h045: {base, shifted} = {8'h30, 8'h29};
         9'h00E: {base, shifted} = {8'h60, 8'h7E};
         9'h04E: {base, shifted} = {8'h2D, 8'h5F};
         9'h055: {base, shifted} = {8'h3D, 8'h2B};
         9'h054: {base, shifted} = {8'h5B, 8'h7B};
         9'h05B: {base, shifted} = {8'h5D, 8'h7D};
         9'h05D: {base, shifted} = {8'h5C, 8'h7C};
         9'h04C: {base, shifted} = {8'h3B, 8'h3A};
         9'h052: {base, shifted} = {8'h27, 8'h22};
         9'h041: {base, shifted} = {8'h2C, 8'h3C};
         9'h049: {base, shifted} = {8'h2E, 8'h3E};
         9'h04A: {base, shifted} = {8'h2F, 8'h3F};
         9'h029: base = 8'h20;
         9'h079: base = 8'h2B;  9'h07B: base = 8'h2D;  9'h07C: base = 8'h2A;
         9'h14A: base = 8'h2F;
         9'h05A, 9'h15A: base = KEY_NEWLINE;
         9'h066: base = KEY_BACKSPACE;
         9'h16B: base = KEY_LEFT;    9'h175: base = KEY_UP;
         9'h174: base = KEY_RIGHT;   9'h172: base = KEY_DOWN;
         9'h16C: base = KEY_HOME;    9'h169: base = KEY_END;
         9'h17D: base = KEY_PGUP;    9'h17A: base = KEY_PGDN;
         9'h170: base = KEY_INSERT;  9'h171: base = KEY_DELETE;
         9'h076: base = KEY_ESC;
         9'h005: base = KEY_F1;          9'h006: base = KEY_F1 + 8'd1;
         9'h004: base = KEY_F1 + 8'd2;   9'h00C: base = KEY_F1 + 8'd3;
         9'h003: base = KEY_F1 + 8'd4;   9'h00B: base = KEY_F1 + 8'd5;
         9'h083: base = KEY_F1 + 8'd6;   9'h00A: base = KEY_F1 + 8'd7;
         9'h001: base = KEY_F1 + 8'd8;   9'h009: base = KEY_F1 + 8'd9;
         9'h078: base = KEY_F1 + 8'd10;  9'h007: base = KEY_F1 + 8'd11;
         default: base = '0;
      endcase
      // Keys without a distinct shifted symbol translate the same either way.
      if (shifted == 8'h00) shifted = base;
   end

   assign letter = (base >= 8'h41) && (base <= 8'h5A);

   always_comb begin
      if (letter)
         code = (CASE_ENABLE && !shift) ? (base | 8'h20) : base;
      else
         code = (CASE_ENABLE && shift) ? shifted : base;
   end

endmodule

// File: rtl/hack_keyboard_ctrl.sv
// PS/2 event bus to Hack keyboard bridge: event detect, shift tracking,
// held-key stack driving hack_scancode, and a buffered keystroke queue.
module hack_keyboard_ctrl
   import hack_kbd_pkg::*;
#(
   parameter int HELD_KEYS   = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter bit CASE_ENABLE = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [10:0]                    ps2_key,
   output logic [7:0]                     hack_scancode,
   output logic                           shift_held,
   output logic [$clog2(HELD_KEYS+1)-1:0] held_count,
   output logic                           ev_valid,
   input  logic                           ev_ready,
   output logic [7:0]                     ev_data,
   output logic                           ev_overflow
);

   localparam int CW = $clog2(HELD_KEYS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic        tog_p0, primed, vld_p0;
   logic [9:0]  key_p0;
   logic        shift_l, shift_r;
   held_ent_t   stk     [HELD_KEYS];
   held_ent_t   stk_nxt [HELD_KEYS];
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]  top_nxt, map_code, push_code;
   logic        push, hit, is_shift;
   int          hit_idx;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   occ;
   logic        pop, full, push_ok;

   // Stage p0: toggle edge detect; the first clock after reset only primes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tog_p0 <= 1'b0;
         primed <= 1'b0;
         vld_p0 <= 1'b0;
         key_p0 <= '0;
      end else begin
         tog_p0 <= ps2_key[10];
         primed <= 1'b1;
         vld_p0 <= primed && (ps2_key[10] != tog_p0);
         key_p0 <= ps2_key[9:0];
      end
   end

   // Stage p1: translate with the current shift state and update the stack.
   assign is_shift = (key_p0[8:0] == SHIFT_L_ID) || (key_p0[8:0] == SHIFT_R_ID);

   hack_keymap #(.CASE_ENABLE(CASE_ENABLE)) u_keymap (
      .id    (key_p0[8:0]),
      .shift (shift_held),
      .code  (map_code)
   );

   always_comb begin
      stk_nxt   = stk;
      cnt_nxt   = cnt;
      push      = 1'b0;
      push_code = '0;
      hit       = 1'b0;
      hit_idx   = 0;
      top_nxt   = '0;
      for (int i = 0; i < HELD_KEYS; i++)
         if (i < int'(cnt) && stk[i].id == key_p0[8:0]) begin
            hit     = 1'b1;
            hit_idx = i;
         end
      if (vld_p0 && !is_shift) begin
         if (key_p0[9] && hit) begin
            push = 1'b1;
            for (int i = 0; i < HELD_KEYS; i++)
               if (i == hit_idx) push_code = stk[i].code;
         end else if (key_p0[9] && map_code != 8'h00) begin
            push      = 1'b1;
            push_code = map_code;
            if (cnt == CW'(HELD_KEYS)) begin
               for (int i = 0; i < HELD_KEYS - 1; i++) stk_nxt[i] = stk[i+1];
               stk_nxt[HELD_KEYS-1] = '{id: key_p0[8:0], code: map_code};
            end else begin
               for (int i = 0; i < HELD_KEYS; i++)
                  if (i == int'(cnt)) stk_nxt[i] = '{id: key_p0[8:0], code: map_code};
               cnt_nxt = cnt + CW'(1);
            end
         end else if (!key_p0[9] && hit) begin
            for (int i = 0; i < HELD_KEYS - 1; i++)
               if (i >= hit_idx) stk_nxt[i] = stk[i+1];
            stk_nxt[HELD_KEYS-1] = '0;
            cnt_nxt = cnt - CW'(1);
         end
      end
      for (int i = 0; i < HELD_KEYS; i++)
         if (i == int'(cnt_nxt) - 1) top_nxt = stk_nxt[i].code;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < HELD_KEYS; i++) stk[i] <= '0;
         cnt           <= '0;
         hack_scancode <= '0;
         shift_l       <= 1'b0;
         shift_r       <= 1'b0;
      end else begin
         stk           <= stk_nxt;
         cnt           <= cnt_nxt;
         hack_scancode <= top_nxt;
         if (vld_p0 && key_p0[8:0] == SHIFT_L_ID) shift_l <= key_p0[9];
         if (vld_p0 && key_p0[8:0] == SHIFT_R_ID) shift_r <= key_p0[9];
      end
   end

   assign shift_held = shift_l | shift_r;
   assign held_count = cnt;

   // Event queue; a simultaneous pop frees the slot, so full+pop still accepts.
   assign ev_valid = (occ != '0);
   assign ev_data  = mem[rd_ptr];
   assign pop      = ev_valid && ev_ready;
   assign full     = (occ == (AW+1)'(FIFO_DEPTH));
   assign push_ok  = push && (!full || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         ev_overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_code;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop) occ <= occ + (AW+1)'(1);
         else if (pop && !push_ok) occ <= occ - (AW+1)'(1);
         if (push && !push_ok) ev_overflow <= 1'b1;
      end
   end

endmodule
